// File: rtl/uart_tx_feeder_if.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder_if
//   Bundles the producer-side push port and the transmitter-side issue port
//   of uart_tx_feeder.
//
//   master : the environment. It drives wr_en, wr_data and tx_busy (and
//            ovf_clr), and observes the FIFO status and the issue outputs.
//   slave  : the feeder itself.
//
//   Signals
//     wr_en, wr_data[7:0]  push request and byte
//     full, empty          FIFO status, decoded from the registered count
//     count[AW:0]          occupancy, 0..DEPTH
//     tx_busy              busy flag from the transmitter
//     tx_start, tx_data    registered start pulse and byte to the transmitter
//     ovf, ovf_clr         sticky overflow flag and its clear; these exist only
//                          when UART_TX_FEEDER_OVF_FLAG_EN is defined
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_tx_feeder_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    logic          ovf;
    logic          ovf_clr;

    modport master (
        output wr_en, wr_data, tx_busy, ovf_clr,
        input  full, empty, count, tx_start, tx_data, ovf
    );

    modport slave (
        input  wr_en, wr_data, tx_busy, ovf_clr,
        output full, empty, count, tx_start, tx_data, ovf
    );
`else
    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, tx_start, tx_data
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, tx_start, tx_data
    );
`endif

endinterface

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//   Byte FIFO and issue controller sitting directly in front of the UART
//   transmitter. Producers push bytes at any rate; the feeder hands one byte
//   at a time to the transmitter with a registered one-cycle tx_start pulse,
//   then waits for tx_busy to rise and fall before issuing the next byte.
//
//   Parameters
//     DEPTH  FIFO entries; must be a power of 2 and >= 2 (pointers wrap
//            naturally at AW bits).
//
//   Ports
//     clk    system clock
//     rst    asynchronous, active-high reset
//     bus    uart_tx_feeder_if.slave: push port, FIFO status, issue port
//
//   Build option
//     UART_TX_FEEDER_OVF_FLAG_EN  adds the sticky overflow flag bus.ovf,
//     set by any push attempted while full and cleared by rst or
//     bus.ovf_clr (clear wins). Without it overflows are silently dropped.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_feeder #(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_feeder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e        state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q,  tx_data_d;
    logic [7:0]    mem_q [DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Status flags are pure decodes of the registered occupancy.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;

        // A push while full is dropped even if a pop happens on the same
        // edge, because full comes from the registered count.
        push = bus.wr_en && !full;

        case (state_q)
            IDLE: begin
                if (!empty && !bus.tx_busy) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    state_d    = START;
                end
            end
            START: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only read after
    // being written, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else if (bus.wr_en && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
//   Self-checking bench for uart_tx_feeder (DEPTH = 16). A cycle-stepped
//   vector table covers the basic push/issue/handshake sequencing with a
//   hand-driven tx_busy. Hand-written sequences then cover latency, ordering
//   against a simple transmitter model, overflow, wrap-around, issue while
//   full, and reset mid-operation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_feeder;

    localparam int DEPTH    = 16;
    localparam int BUSY_LEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // tx_busy comes either from the transmitter model or straight from the bench.
    logic model_en    = 1'b0;
    logic forced_busy = 1'b0;
    logic model_busy  = 1'b0;
    int   model_delay = 0;
    int   model_left  = 0;

    assign bus.tx_busy = model_en ? model_busy : forced_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap_cnt = 0;
    logic [7:0] seen_q [$];

    // Transmitter model plus issue monitor. Busy rises 2 cycles after the
    // start pulse and stays high for BUSY_LEN cycles.
    always @(negedge clk) begin
        if (rst) begin
            model_delay = 0;
            model_left  = 0;
            model_busy  = 1'b0;
        end else if (bus.tx_start) begin
            seen_q.push_back(bus.tx_data);
            if (model_en && (model_busy || model_delay != 0 || model_left != 0)) begin
                overlap_cnt++;
            end
            model_delay = 2;
        end else if (model_delay != 0) begin
            model_delay--;
            if (model_delay == 0) begin
                model_busy = 1'b1;
                model_left = BUSY_LEN;
            end
        end else if (model_left != 0) begin
            model_left--;
            if (model_left == 0) begin
                model_busy = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] seen_at(input int i);
        if (i < seen_q.size()) begin
            return {24'h0, seen_q[i]};
        end
        return 32'hFFFF_FFFF;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Waits until the FIFO is empty and the transmitter model is idle.
    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!(bus.empty && !bus.tx_start && !model_busy &&
                 model_delay == 0 && model_left == 0) && n < budget) begin
            tick();
            n++;
        end
        check({name, " drain within budget"}, 32'(n < budget), 32'd1);
    endtask

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       busy;
        logic [4:0] exp_count;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_start;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
        bus.ovf_clr = 1'b0;
`endif

        //            wr  data  busy cnt emp full st  data
        vecs[0]  = '{1'b1, 8'h55, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'h66, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h55};
        vecs[3]  = '{1'b1, 8'h77, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h66};
        vecs[8]  = '{1'b1, 8'h88, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h66};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h66};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h66};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h66};
        vecs[12] = '{1'b1, 8'h99, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 8'h77};

        // Reset values, sampled while rst is held.
        repeat (3) @(negedge clk);
        check("reset tx_start", 32'(bus.tx_start), 32'd0);
        check("reset tx_data",  32'(bus.tx_data),  32'h00);
        check("reset count",    32'(bus.count),    32'd0);
        check("reset empty",    32'(bus.empty),    32'd1);
        check("reset full",     32'(bus.full),     32'd0);
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
        check("reset ovf",      32'(bus.ovf),      32'd0);
`endif
        rst = 1'b0;

        // Cycle-stepped vectors with hand-driven tx_busy.
        for (int i = 0; i < 13; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_data = vecs[i].wr_data;
            forced_busy = vecs[i].busy;
            tick();
            check($sformatf("vec%0d count", i), 32'(bus.count),    32'(vecs[i].exp_count));
            check($sformatf("vec%0d empty", i), 32'(bus.empty),    32'(vecs[i].exp_empty));
            check($sformatf("vec%0d full", i),  32'(bus.full),     32'(vecs[i].exp_full));
            check($sformatf("vec%0d start", i), 32'(bus.tx_start), 32'(vecs[i].exp_start));
            check($sformatf("vec%0d data", i),  32'(bus.tx_data),  32'(vecs[i].exp_data));
        end
        bus.wr_en   = 1'b0;
        forced_busy = 1'b0;

        // Single byte latency against the transmitter model.
        do_reset();
        model_en = 1'b1;
        seen_q.delete();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h41;
        tick();
        bus.wr_en = 1'b0;
        check("lat start after push edge", 32'(bus.tx_start), 32'd0);
        check("lat count after push",      32'(bus.count),    32'd1);
        tick();
        check("lat start pulse",   32'(bus.tx_start), 32'd1);
        check("lat tx_data",       32'(bus.tx_data),  32'h41);
        check("lat empty at issue", 32'(bus.empty),   32'd1);
        tick();
        check("lat pulse one cycle", 32'(bus.tx_start), 32'd0);
        wait_drain("lat", 100);
        check("lat pulse count", 32'(seen_q.size()), 32'd1);

        // Three consecutive pushes: ordered issue, each after busy has fallen.
        seen_q.delete();
        overlap_cnt = 0;
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        wait_drain("seq3", 200);
        check("seq3 pulse count", 32'(seen_q.size()), 32'd3);
        check("seq3 byte0", seen_at(0), 32'h31);
        check("seq3 byte1", seen_at(1), 32'h32);
        check("seq3 byte2", seen_at(2), 32'h33);
        check("seq3 issue while busy", 32'(overlap_cnt), 32'd0);

        // Overflow: 17 pushes with the transmitter held busy.
        do_reset();
        model_en    = 1'b0;
        forced_busy = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            push_byte(8'(i));
        end
        check("ovf count", 32'(bus.count),    32'd16);
        check("ovf full",  32'(bus.full),     32'd1);
        check("ovf empty", 32'(bus.empty),    32'd0);
        check("ovf start", 32'(bus.tx_start), 32'd0);
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
        check("ovf flag set", 32'(bus.ovf), 32'd1);
        repeat (3) tick();
        check("ovf flag sticky", 32'(bus.ovf), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf flag cleared", 32'(bus.ovf), 32'd0);
        tick();
        check("ovf flag stays clear", 32'(bus.ovf), 32'd0);
`endif

        // Full and idle: release busy and push on the issue edge.
        seen_q.delete();
        overlap_cnt = 0;
        model_en    = 1'b1;
        push_byte(8'hEE);
        check("fullpush count", 32'(bus.count),    32'd15);
        check("fullpush start", 32'(bus.tx_start), 32'd1);
        check("fullpush data",  32'(bus.tx_data),  32'h00);
        check("fullpush full",  32'(bus.full),     32'd0);
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
        check("fullpush ovf", 32'(bus.ovf), 32'd1);
`endif
        wait_drain("fullpush", 800);
        check("fullpush drained count", 32'(seen_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fullpush byte%0d", i), seen_at(i), 32'(i));
        end
        check("fullpush end count", 32'(bus.count), 32'd0);
        check("fullpush issue while busy", 32'(overlap_cnt), 32'd0);

        // Wrap-around: 20 bytes in bursts of 5.
        seen_q.delete();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 5; k++) begin
                push_byte(8'(8'hA0 + b * 5 + k));
            end
            wait_drain($sformatf("wrap burst%0d", b), 300);
        end
        check("wrap pulse count", 32'(seen_q.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap byte%0d", i), seen_at(i), 32'(8'hA0 + i));
        end
        check("wrap end count", 32'(bus.count), 32'd0);
        check("wrap end empty", 32'(bus.empty), 32'd1);

        // Reset during WAIT_DONE with 4 bytes queued.
        do_reset();
        model_en    = 1'b0;
        forced_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'(8'hC0 + i));
        end
        check("rst5 count", 32'(bus.count), 32'd5);
        forced_busy = 1'b0;
        tick();
        check("rst5 issue start", 32'(bus.tx_start), 32'd1);
        check("rst5 issue data",  32'(bus.tx_data),  32'hC0);
        tick();
        forced_busy = 1'b1;
        tick();
        tick();
        check("rst5 queued", 32'(bus.count), 32'd4);
        rst = 1'b1;
        #1;
        check("rstmid start", 32'(bus.tx_start), 32'd0);
        check("rstmid count", 32'(bus.count),    32'd0);
        check("rstmid empty", 32'(bus.empty),    32'd1);
        check("rstmid data",  32'(bus.tx_data),  32'h00);
        @(negedge clk);
        seen_q.delete();
        rst = 1'b0;
        forced_busy = 1'b0;
        repeat (20) tick();
        check("rstmid no issue after", 32'(seen_q.size()), 32'd0);
        check("rstmid count after",    32'(bus.count),     32'd0);

        // Reset asserted during the start cycle drops tx_start at once.
        push_byte(8'h5A);
        tick();
        check("rststart pulse", 32'(bus.tx_start), 32'd1);
        rst = 1'b1;
        #1;
        check("rststart drop", 32'(bus.tx_start), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
